fsq_square: RTL and testbench

- Iterative fixed-point squarer; the inverse operation of the restoring square-root unit in the FPU datapath.
- Takes an unsigned fraction mantissa 0.x1x2...xW and computes its exact 2W-bit square with a radix-2 shift-add, one bit per cycle.
- Normalizes the square left until its MSB is 1, then returns the top W bits plus a sticky bit and the shift amount for exponent adjustment.
- Sits beside the sqrt unit for the square/verify path, with the same out/sticky/done output convention.

---
 rtl/fsq_square.sv | 129 ++++++++++++
 tb/tb_fsq_square.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fsq_square.sv
// Iterative fixed-point squarer: radix-2 shift-add over WIDTH cycles, then a one-cycle
// leading-zero normalization that returns the top WIDTH bits, a sticky bit and the
// left-shift amount for exponent adjustment.
module fsq_square #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SHW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             sticky,
    output logic [SHW-1:0]   shamt,
    output logic             zero
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sticky_q, sticky_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             zero_q, zero_d;

    logic [SHW-1:0]   lz;
    logic [PW-1:0]    norm;

    // Priority leading-zero count of the finished product; highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (acc_q[i]) lz = SHW'(PW - 1 - i);
        end
        norm = acc_q << lz;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        sticky_d = sticky_q;
        shamt_d  = shamt_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = in;
                    mplier_d = in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StMul;
                end
            end
            StMul: begin
                // Partial products never overflow: WIDTH x WIDTH fits in 2*WIDTH bits.
                if (mplier_q[cnt_q]) acc_d = acc_q + (PW'(mcand_q) << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = StNorm;
            end
            StNorm: begin
                if (acc_q == '0) begin
                    out_d    = '0;
                    sticky_d = 1'b0;
                    shamt_d  = '0;
                    zero_d   = 1'b1;
                end else begin
                    out_d    = norm[PW-1:WIDTH];
                    sticky_d = |norm[WIDTH-1:0];
                    shamt_d  = lz;
                    zero_d   = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; results hold until the next normalization.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            sticky_q <= 1'b0;
            shamt_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            sticky_q <= sticky_d;
            shamt_q  <= shamt_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign out    = out_q;
    assign sticky = sticky_q;
    assign shamt  = shamt_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_fsq_square.sv
// Self-checking bench for fsq_square: transaction-level reference model plus a
// per-cycle compare process, directed literal cases, reset and random sweeps.
module tb_fsq_square;

    localparam int unsigned W   = 8;
    localparam int unsigned SHW = $clog2(2 * W);
    localparam int unsigned RW  = W + 1 + SHW + 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   din;
    logic           busy;
    logic           done;
    logic [W-1:0]   dout;
    logic           sticky;
    logic [SHW-1:0] shamt;
    logic           zero;

    int errors;
    int checks;

    fsq_square #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (din),
        .busy  (busy),
        .done  (done),
        .out   (dout),
        .sticky(sticky),
        .shamt (shamt),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packed as {out, sticky, shamt, zero}: exact square, shifted until its MSB is set.
    function automatic logic [RW-1:0] sq_model(input logic [W-1:0] a);
        longint unsigned p;
        int k;
        p = longint'(a) * longint'(a);
        if (p == 0) return {{W{1'b0}}, 1'b0, {SHW{1'b0}}, 1'b1};
        k = 0;
        while (p < (64'd1 << (2 * W - 1))) begin
            p = p * 2;
            k++;
        end
        return {W'(p >> W), (p % (64'd1 << W)) != 0, SHW'(k), 1'b0};
    endfunction

    // Hand-computed results for a few operands.
    function automatic bit lit_lookup(input logic [W-1:0] a, output logic [RW-1:0] r);
        r = '0;
        case (a)
            8'h80: begin r = {8'h80, 1'b0, 4'd1,  1'b0}; return 1; end
            8'hFF: begin r = {8'hFE, 1'b1, 4'd0,  1'b0}; return 1; end
            8'hB5: begin r = {8'hFF, 1'b1, 4'd1,  1'b0}; return 1; end
            8'h01: begin r = {8'h80, 1'b0, 4'd15, 1'b0}; return 1; end
            8'h00: begin r = {8'h00, 1'b0, 4'd0,  1'b1}; return 1; end
            default: return 0;
        endcase
    endfunction

    // Model: phase 0 = idle, 1..W = multiply, W+1 = normalize, W+2 = done.
    int           m_phase;
    logic [W-1:0] m_op;
    logic [RW-1:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_op    <= '0;
            m_res   <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_op    <= din;
            end
        end else if (m_phase == W + 2) begin
            m_phase <= 0;
        end else begin
            if (m_phase == W + 1) m_res <= sq_model(m_op);
            m_phase <= m_phase + 1;
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare process.
    initial begin
        logic [RW-1:0] lit;
        longint unsigned v;
        longint unsigned r;
        forever begin
            @(negedge clk);
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == W + 2);
            chk("out", dout, m_res[RW-1 -: W]);
            chk("sticky", sticky, m_res[SHW+1]);
            chk("shamt", shamt, m_res[SHW:1]);
            chk("zero", zero, m_res[0]);
            if (m_phase == W + 2) begin
                if (lit_lookup(m_op, lit)) begin
                    chk("lit_dut", {dout, sticky, shamt, zero}, lit);
                    chk("lit_model", m_res, lit);
                end
                if (m_op[W-1]) begin
                    // Truncated square fed back through an integer square root.
                    v = ({64'd0, dout} << W) >> shamt;
                    r = 0;
                    while ((r + 1) * (r + 1) <= v) r++;
                    chk("sqrt_back", (r + 1 >= m_op) && (r <= m_op + 1), 1);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] v);
        @(negedge clk);
        start = 1'b1;
        din   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = W'($urandom);
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] perm [256];
        int j;
        logic [W-1:0] tmp;
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        start  = 1'b0;
        din    = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        run_op(8'h80);
        run_op(8'hFF);
        run_op(8'hB5);
        run_op(8'h01);
        run_op(8'h00);
        run_op(8'hFF);

        // Asynchronous reset during the third multiply cycle.
        @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);

        // start held high with a new operand every cycle.
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            start = 1'b1;
            din   = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        // All operands in shuffled order with random idle gaps.
        for (int i = 0; i < 256; i++) perm[i] = W'(i);
        for (int i = 255; i > 0; i--) begin
            j       = $urandom_range(i, 0);
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            run_op(perm[i]);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
